// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO through a two-cycle read strobe and shifts
// each byte out as a UART 8N1 frame, back-to-back while data and enable remain.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       empty,
  input  logic [7:0] rd_data,
  output logic       rd_fifo,
  output logic       tx,
  output logic       busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, REQ, FETCH, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [7:0] r_shreg;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0] r_bit_idx;
  logic w_bit_done, w_go;
  assign w_bit_done = r_baud_cnt == BAUD_MAX;
  assign w_go = tx_en & ~empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? REQ : IDLE;
      REQ:     w_next = FETCH;
      FETCH:   w_next = START;
      START:   w_next = w_bit_done ? DATA : START;
      DATA:    w_next = (w_bit_done && r_bit_idx == 3'd7) ? STOP : DATA;
      STOP:    w_next = w_bit_done ? (w_go ? REQ : IDLE) : STOP;
      default: w_next = IDLE;
    endcase
  end
  // The baud counter only runs while a frame is on the line; FETCH leaves it cleared.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shreg    <= '0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end else begin
      r_baud_cnt <= (r_state inside {START, DATA, STOP}) ? (w_bit_done ? '0 : r_baud_cnt + 1'b1) : '0;
      if (r_state == FETCH) r_shreg <= rd_data;
      else if (r_state == DATA && w_bit_done) r_shreg <= r_shreg >> 1;
      if (r_state == FETCH) r_bit_idx <= '0;
      else if (r_state == DATA && w_bit_done) r_bit_idx <= r_bit_idx + 3'd1;
    end
  always_comb begin
    rd_fifo = r_state == REQ || r_state == FETCH;
    tx      = r_state == START ? 1'b0 : r_state == DATA ? r_shreg[0] : 1'b1;
    busy    = r_state != IDLE;
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench with a behavioural FIFO and a frame decoder
// that pops expected bytes from a scoreboard queue.
module tb_fifo_uart_tx;
  logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, empty = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic rd_fifo, tx, busy;
  logic tx_en16 = 1'b0, empty16 = 1'b1;
  logic [7:0] rd_data16 = 8'h55;
  logic rd16, tx16, busy16;
  int n_cmp = 0, n_err = 0, cyc = 0, rd_cnt = 0;
  logic [7:0] mem[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp16[$];
  int starts[$];
  logic rd_ph = 1'b0;
  logic [9:0] m_f;
  bit m_ok, m_stab;
  logic s_tx[161];
  logic s_busy[161];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .empty(empty), .rd_data(rd_data),
    .rd_fifo(rd_fifo), .tx(tx), .busy(busy));

  fifo_uart_tx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en16), .empty(empty16), .rd_data(rd_data16),
    .rd_fifo(rd16), .tx(tx16), .busy(busy16));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_fifo) rd_cnt <= rd_cnt + 1;
  end

  // FIFO model: registered empty lags the pop; head is valid in the second strobe cycle.
  always @(posedge clk) begin
    empty <= mem.size() == 0;
    if (!rst_n) rd_ph <= 1'b0;
    else begin
      if (rd_fifo && rd_ph && mem.size() > 0) void'(mem.pop_front());
      rd_ph <= rd_fifo && !rd_ph;
    end
    rd_data <= (mem.size() > 0) ? mem[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i = 0;
    while (starts.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("wait_frame", starts.size(), n);
  endtask

  // Frame decoder for the CLKS_PER_BIT=4 instance; frames cut by reset are discarded.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx === 1'b0) begin
      m_ok = 1'b1;
      m_stab = 1'b1;
      starts.push_back(cyc);
      for (int b = 0; b < 10; b++)
        for (int s = 0; s < 4; s++) begin
          if (b != 0 || s != 0) @(negedge clk);
          if (!rst_n) m_ok = 1'b0;
          if (s == 0) m_f[b] = tx;
          else if (tx !== m_f[b]) m_stab = 1'b0;
        end
      if (m_ok) begin
        chk("frame_start", m_f[0], 0);
        chk("frame_stop", m_f[9], 1);
        chk("frame_stable", m_stab, 1);
        chk("frame_queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("frame_data", m_f[8:1], exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, r0, i, bad;
    logic [7:0] d, pat;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_rd", rd_fifo, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tx_en = 1'b1;
    tx_en16 = 1'b1;
    // Reset mid-frame
    mem.push_back(8'h11);
    wait_frames(1, 40);
    repeat (8) @(negedge clk);
    chk("t1_mid_busy", busy, 1);
    chk("t1_mid_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_tx", tx, 1);
    chk("t1_rst_rd", rd_fifo, 0);
    chk("t1_rst_busy", busy, 0);
    mem.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_cnt;
    repeat (50) @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rd", rd_cnt - r0, 0);
    chk("t1_no_frame", starts.size(), 1);
    // Single byte
    r0 = rd_cnt;
    n = starts.size();
    push_byte(8'hA5);
    c = cyc;
    wait_frames(n + 1, 20);
    chk("t2_latency", starts[n], c + 4);
    repeat (60) @(negedge clk);
    chk("t2_rd_cycles", rd_cnt - r0, 2);
    chk("t2_busy", busy, 0);
    chk("t2_empty", empty, 1);
    chk("t2_frames", starts.size(), n + 1);
    // Back-to-back
    r0 = rd_cnt;
    n = starts.size();
    push_byte(8'h00);
    @(negedge clk);
    push_byte(8'hFF);
    @(negedge clk);
    push_byte(8'h3C);
    wait_frames(n + 3, 200);
    chk("t3_period1", starts[n + 1] - starts[n], 42);
    chk("t3_period2", starts[n + 2] - starts[n + 1], 42);
    repeat (60) @(negedge clk);
    chk("t3_rd_cycles", rd_cnt - r0, 6);
    chk("t3_sb_drained", exp_q.size(), 0);
    // Enable drop mid-frame
    r0 = rd_cnt;
    n = starts.size();
    push_byte(8'h5A);
    @(negedge clk);
    push_byte(8'hC3);
    wait_frames(n + 1, 20);
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    repeat (60) @(negedge clk);
    chk("t4_no_next", starts.size(), n + 1);
    chk("t4_rd_cycles", rd_cnt - r0, 2);
    chk("t4_fifo_kept", mem.size(), 1);
    chk("t4_busy", busy, 0);
    c = cyc;
    tx_en = 1'b1;
    wait_frames(n + 2, 20);
    chk("t4_resume_latency", starts[n + 1], c + 3);
    repeat (50) @(negedge clk);
    // Refill during stop bit
    r0 = rd_cnt;
    n = starts.size();
    push_byte(8'h81);
    wait_frames(n + 1, 20);
    c = starts[n];
    i = 0;
    while (cyc < c + 37 && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk("t5_in_stop_tx", tx, 1);
    chk("t5_in_stop_busy", busy, 1);
    push_byte(8'h7E);
    wait_frames(n + 2, 20);
    chk("t5_gap", starts[n + 1] - starts[n], 42);
    repeat (60) @(negedge clk);
    chk("t5_rd_cycles", rd_cnt - r0, 4);
    chk("t5_busy", busy, 0);
    // CLKS_PER_BIT = 16
    exp16.push_back(8'h55);
    empty16 = 1'b0;
    i = 0;
    while (!rd16 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("t6_rd", rd16, 1);
    @(negedge clk);
    empty16 = 1'b1;
    i = 0;
    while (tx16 !== 1'b0 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("t6_start", tx16, 0);
    s_tx[0] = tx16;
    s_busy[0] = busy16;
    for (int k = 1; k < 161; k++) begin
      @(negedge clk);
      s_tx[k] = tx16;
      s_busy[k] = busy16;
    end
    pat = 8'h55;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int k = 0; k < 16; k++)
        if (s_tx[16 * b + k] !== ((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : pat[b - 1])) bad++;
      chk($sformatf("t6_bit%0d_bad_samples", b), bad, 0);
    end
    for (int b = 0; b < 8; b++) d[b] = s_tx[16 * (b + 1) + 8];
    chk("t6_data", d, exp16.pop_front());
    chk("t6_busy_last", s_busy[159], 1);
    chk("t6_busy_end", s_busy[160], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
